// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the stack access unit: request op codes, the
// three-state FSM encoding and the default geometry of the stack region.
// -----------------------------------------------------------------------------
package stack_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_PEEK = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  localparam int          DEFAULT_DEPTH     = 256;
  localparam logic [31:0] DEFAULT_STACK_TOP = 32'h0000_0400;

endpackage

// File: rtl/stack_access_unit_if.sv
// -----------------------------------------------------------------------------
// stack_access_unit_if
// Request/response bundle between the ALU-side requester and the stack unit.
//   req_valid/req_op/push_data/esp_in : request (master -> slave)
//   ready                              : slave can accept a request
//   rsp_valid/rsp_err/pop_data         : one-cycle completion
//   esp_out/esp_load                   : new ESP and its register write strobe
// -----------------------------------------------------------------------------
interface stack_access_unit_if;

  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] push_data;
  logic [31:0] esp_in;
  logic        ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] pop_data;
  logic [31:0] esp_out;
  logic        esp_load;

  modport master (
    output req_valid, req_op, push_data, esp_in,
    input  ready, rsp_valid, rsp_err, pop_data, esp_out, esp_load
  );

  modport slave (
    input  req_valid, req_op, push_data, esp_in,
    output ready, rsp_valid, rsp_err, pop_data, esp_out, esp_load
  );

endinterface

// File: rtl/stack_ram.sv
// -----------------------------------------------------------------------------
// stack_ram
// DEPTH x 32 single-port synchronous RAM with registered read, no reset.
//   clk   : clock
//   we    : write enable for this cycle
//   addr  : word index
//   wdata : write data
//   rdata : word at addr, one cycle after the address is presented
// -----------------------------------------------------------------------------
module stack_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/stack_access_unit.sv
// -----------------------------------------------------------------------------
// stack_access_unit
// Push/pop/peek stage between the ALU result bus, the ESP register and a
// private downward-growing stack RAM. One request every three cycles:
// IDLE (accept) -> ACCESS (RAM access on the exit edge) -> RESP (outputs).
//   clk   : clock
//   reset : asynchronous, active-low
//   bus   : request/response bundle (slave side)
// -----------------------------------------------------------------------------
module stack_access_unit
  import stack_pkg::*;
#(
  parameter int          DEPTH     = DEFAULT_DEPTH,
  parameter logic [31:0] STACK_TOP = DEFAULT_STACK_TOP
) (
  input  logic               clk,
  input  logic               reset,
  stack_access_unit_if.slave bus
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] SPAN       = 32'(4 * DEPTH);
  localparam logic [31:0] STACK_BASE = STACK_TOP - SPAN;

  state_e      state_reg, state_next;
  op_e         op_reg;
  logic        err_reg;
  logic [AW-1:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] esp_new_reg;

  op_e         op_in;
  logic        accept;
  logic [31:0] esp_off;
  logic        err_in;
  logic [31:0] esp_new_in;
  logic [AW-1:0] addr_in;
  logic        ram_we;
  logic [31:0] rdata;

  assign op_in  = op_e'(bus.req_op);
  assign accept = bus.req_valid && bus.ready;

  // Offset from the bottom of the stack region. An esp_in below the base
  // wraps to a huge value, so one unsigned compare covers both range ends
  // before any ESP arithmetic is applied.
  assign esp_off = bus.esp_in - STACK_BASE;

  always_comb begin
    err_in     = (bus.esp_in[1:0] != 2'b00) || (esp_off > SPAN);
    esp_new_in = bus.esp_in;
    addr_in    = AW'(esp_off >> 2);
    case (op_in)
      OP_PUSH: begin
        err_in     = err_in || (esp_off == 32'd0);
        esp_new_in = bus.esp_in - 32'd4;
        addr_in    = AW'((esp_off - 32'd4) >> 2);
      end
      OP_POP: begin
        err_in     = err_in || (esp_off == SPAN);
        esp_new_in = bus.esp_in + 32'd4;
      end
      OP_PEEK: begin
        err_in     = err_in || (esp_off == SPAN);
      end
      default: begin
        err_in     = 1'b1;
      end
    endcase
    // A rejected request reports the ESP unchanged.
    if (err_in) begin
      esp_new_in = bus.esp_in;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg      <= OP_PUSH;
      err_reg     <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      esp_new_reg <= '0;
    end else if (accept) begin
      op_reg      <= op_in;
      err_reg     <= err_in;
      addr_reg    <= addr_in;
      wdata_reg   <= bus.push_data;
      esp_new_reg <= esp_new_in;
    end
  end

  // The write enable is a function of the state register, so an async
  // reset landing in ACCESS drops it before the next edge.
  assign ram_we = (state_reg == ACCESS) && !err_reg && (op_reg == OP_PUSH);

  stack_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_reg),
    .wdata (wdata_reg),
    .rdata (rdata)
  );

  // Output logic
  always_comb begin
    bus.ready     = (state_reg == IDLE) && reset;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.pop_data  = '0;
    bus.esp_out   = '0;
    bus.esp_load  = 1'b0;
    if (state_reg == RESP) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_err   = err_reg;
      bus.esp_out   = esp_new_reg;
      bus.esp_load  = !err_reg && (op_reg != OP_PEEK);
      if (!err_reg && (op_reg != OP_PUSH)) begin
        bus.pop_data = rdata;
      end
    end
  end

endmodule

// File: tb/tb_stack_access_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_access_unit
// Directed stimulus with literal expectations; a byte-addressed stack model
// predicts every response and one compare process checks the DUT each cycle.
// -----------------------------------------------------------------------------
module tb_stack_access_unit;

  localparam int          DEPTH = 256;
  localparam logic [31:0] TOP   = 32'h0000_0400;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] esp;
    logic        load;
    logic [31:0] pop;
    bit          chk_pop;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   busy_lo = -10;
  bit   in_rst = 1'b1;

  exp_t        q[$];
  logic [31:0] smem [logic [31:0]];

  stack_access_unit_if bus_if ();

  stack_access_unit #(
    .DEPTH     (DEPTH),
    .STACK_TOP (TOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Stack model: byte-addressed words, rules applied with unbounded arithmetic.
  task automatic model(input logic [1:0] op, input logic [31:0] esp,
                       input logic [31:0] data, output exp_t e);
    longint a, base, top;
    a = longint'(esp);
    top = longint'(TOP);
    base = top - 4 * DEPTH;
    e.err = (a % 4 != 0) || (a < base) || (a > top) || (op == 2'b11) ||
            (op == 2'b00 && a == base) || (op != 2'b00 && a == top);
    e.esp = esp;
    e.load = 1'b0;
    e.pop = 32'h0;
    e.chk_pop = 1'b1;
    if (!e.err) begin
      case (op)
        2'b00: begin
          smem[esp - 32'd4] = data;
          e.esp = esp - 32'd4;
          e.load = 1'b1;
        end
        default: begin
          if (smem.exists(esp)) e.pop = smem[esp];
          else e.chk_pop = 1'b0;
          e.esp = (op == 2'b01) ? esp + 32'd4 : esp;
          e.load = (op == 2'b01);
        end
      endcase
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus_if.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.ready) chk("ready_timeout", {31'b0, bus_if.ready}, 32'd1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] esp, input logic [31:0] data,
                       input logic lerr, input logic [31:0] lesp, input logic lload,
                       input logic [31:0] lpop);
    exp_t e;
    wait_ready();
    model(op, esp, data, e);
    chk("model_err", {31'b0, e.err}, {31'b0, lerr});
    chk("model_esp", e.esp, lesp);
    chk("model_load", {31'b0, e.load}, {31'b0, lload});
    chk("model_pop", e.pop, lpop);
    $display("req op=%0d esp=%h data=%h -> err=%0d esp_out=%h load=%0d pop=%h",
             op, esp, data, e.err, e.esp, e.load, e.pop);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = op;
    bus_if.esp_in    = esp;
    bus_if.push_data = data;
    e.due   = cyc + 2;
    busy_lo = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    bus_if.req_op    = 2'b11;
    bus_if.esp_in    = 32'hFFFF_FFFF;
    bus_if.push_data = 32'h0BAD_0BAD;
  endtask

  // Per-cycle compare against the model's expectations.
  always @(negedge clk) begin
    if (!in_rst) begin
      chk("ready", {31'b0, bus_if.ready},
          {31'b0, !(cyc == busy_lo || cyc == busy_lo + 1)});
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_valid", {31'b0, bus_if.rsp_valid}, 32'd1);
        chk("rsp_err", {31'b0, bus_if.rsp_err}, {31'b0, e.err});
        chk("esp_out", bus_if.esp_out, e.esp);
        chk("esp_load", {31'b0, bus_if.esp_load}, {31'b0, e.load});
        if (e.chk_pop) chk("pop_data", bus_if.pop_data, e.pop);
      end else begin
        chk("rsp_valid_idle", {31'b0, bus_if.rsp_valid}, 32'd0);
        chk("esp_load_idle", {31'b0, bus_if.esp_load}, 32'd0);
      end
    end
  end

  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.req_op    = 2'b00;
    bus_if.esp_in    = 32'h0;
    bus_if.push_data = 32'h0;

    // Reset state while asserted and after release
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, bus_if.ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus_if.rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, bus_if.rsp_err}, 32'd0);
    chk("rst_pop_data", bus_if.pop_data, 32'd0);
    chk("rst_esp_out", bus_if.esp_out, 32'd0);
    chk("rst_esp_load", {31'b0, bus_if.esp_load}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", {31'b0, bus_if.ready}, 32'd1);
    in_rst = 1'b0;

    // Basic push / peek / pop
    issue(2'b00, 32'h400, 32'hDEADBEEF, 1'b0, 32'h3FC, 1'b1, 32'h0);
    issue(2'b10, 32'h3FC, 32'h0,        1'b0, 32'h3FC, 1'b0, 32'hDEADBEEF);
    issue(2'b01, 32'h3FC, 32'h0,        1'b0, 32'h400, 1'b1, 32'hDEADBEEF);
    // Empty / full / misaligned / out of range / reserved
    issue(2'b01, 32'h400, 32'h0,        1'b1, 32'h400, 1'b0, 32'h0);
    issue(2'b00, 32'h000, 32'h11111111, 1'b1, 32'h000, 1'b0, 32'h0);
    issue(2'b10, 32'h3FC, 32'h0,        1'b0, 32'h3FC, 1'b0, 32'hDEADBEEF);
    issue(2'b00, 32'h3FE, 32'h22222222, 1'b1, 32'h3FE, 1'b0, 32'h0);
    issue(2'b01, 32'h404, 32'h0,        1'b1, 32'h404, 1'b0, 32'h0);
    issue(2'b11, 32'h3FC, 32'h33333333, 1'b1, 32'h3FC, 1'b0, 32'h0);
    issue(2'b10, 32'h3FC, 32'h0,        1'b0, 32'h3FC, 1'b0, 32'hDEADBEEF);
    issue(2'b00, 32'hFFFF_FFFC, 32'h44444444, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Fill the whole stack, overflow once, then drain in LIFO order
    for (int i = 0; i < DEPTH; i++) begin
      issue(2'b00, 32'h400 - 32'(4 * i), 32'hA500_0000 + 32'(i),
            1'b0, 32'h3FC - 32'(4 * i), 1'b1, 32'h0);
    end
    issue(2'b00, 32'h000, 32'h55555555, 1'b1, 32'h000, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      issue(2'b01, 32'(4 * i), 32'h0,
            1'b0, 32'(4 * i + 4), 1'b1, 32'hA500_0000 + 32'(DEPTH - 1 - i));
    end

    // Reset during ACCESS of a push over a known word
    wait_ready();
    $display("req op=0 esp=00000400 data=cafef00d -> reset in ACCESS, write dropped");
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = 2'b00;
    bus_if.esp_in    = 32'h400;
    bus_if.push_data = 32'hCAFEF00D;
    busy_lo = cyc + 1;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    in_rst = 1'b1;
    reset  = 1'b0;
    #1;
    chk("arst_ready", {31'b0, bus_if.ready}, 32'd0);
    chk("arst_rsp_valid", {31'b0, bus_if.rsp_valid}, 32'd0);
    chk("arst_rsp_err", {31'b0, bus_if.rsp_err}, 32'd0);
    chk("arst_esp_out", bus_if.esp_out, 32'd0);
    chk("arst_esp_load", {31'b0, bus_if.esp_load}, 32'd0);
    chk("arst_pop_data", bus_if.pop_data, 32'd0);
    @(negedge clk);
    chk("arst_no_resp", {31'b0, bus_if.rsp_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("arst_rel_ready", {31'b0, bus_if.ready}, 32'd1);
    in_rst = 1'b0;
    issue(2'b10, 32'h3FC, 32'h0, 1'b0, 32'h3FC, 1'b0, 32'hA500_0000);

    // Push immediately followed by pop of the same word
    issue(2'b00, 32'h400, 32'h5A5A_1234, 1'b0, 32'h3FC, 1'b1, 32'h0);
    issue(2'b01, 32'h3FC, 32'h0,         1'b0, 32'h400, 1'b1, 32'h5A5A_1234);

    repeat (4) @(negedge clk);
    chk("responses_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stack_access_unit.md
# stack_access_unit

Stack memory stage downstream of the ALU: consumes push/pop/peek requests carrying the ALU result and the current ESP value, performs one word access to a private stack RAM, and returns the popped word plus the updated ESP with a load strobe for the ESP register. It completes the push/pop path between `alu_result_bus`, `esp_register` and stack memory. The stack grows downward, x86 style.

## Interface
Parameters:
- `DEPTH`, 256: stack words; power of two.
- `STACK_TOP`, 32'h0000_0400: ESP value of an empty stack; word-aligned, ≥ 4*DEPTH.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces reset state immediately.
- `req_valid`  in  1  request present.
- `req_op`  in  2  00 PUSH, 01 POP, 10 PEEK, 11 reserved.
- `push_data`  in  32  word to push (from ALU result bus).
- `esp_in`  in  32  current ESP.
- `ready`  out  1  high only in IDLE; request accepted when `req_valid && ready` at a rising edge.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_err`  out  1  qualified by `rsp_valid`; request rejected.
- `pop_data`  out  32  popped/peeked word; valid with `rsp_valid` for POP/PEEK without error; otherwise 0.
- `esp_out`  out  32  new ESP; valid with `rsp_valid`.
- `esp_load`  out  1  pulses with `rsp_valid` when ESP must be written (PUSH/POP, no error).

## Operation
- Address: word index = (addr − (STACK_TOP − 4*DEPTH)) >> 2, log2(DEPTH) bits.
- PUSH: addr = esp_in − 4; writes `push_data`; `esp_out` = esp_in − 4.
- POP: addr = esp_in; reads word; `esp_out` = esp_in + 4.
- PEEK: addr = esp_in; reads word; `esp_out` = esp_in; `esp_load` = 0.
- Errors (checked on acceptance; no RAM write, `esp_load` 0, `esp_out` = esp_in, `pop_data` 0):
  - `esp_in[1:0]` ≠ 0.
  - esp_in outside [STACK_TOP − 4*DEPTH, STACK_TOP].
  - PUSH when esp_in == STACK_TOP − 4*DEPTH (full).
  - POP/PEEK when esp_in == STACK_TOP (empty).
  - op 11.
- All 32-bit ESP arithmetic is modulo 2^32; the range check precedes any wrap.
- FSM states:
  - IDLE → ACCESS on acceptance; request fields, error flag and address are latched.
  - ACCESS → RESP unconditionally; the RAM write or read is performed on the edge leaving ACCESS, only if there is no error.
  - RESP → IDLE unconditionally; outputs are driven in RESP.
- No response backpressure; the consumer must take `rsp_valid` when it is presented.

## Timing
- Request accepted at edge N; ACCESS during cycle N+1; `rsp_valid`/`esp_load`/`pop_data` high during cycle N+2; `ready` returns high in cycle N+3.
- Throughput is one request per 3 cycles. `ready` is low in ACCESS and RESP, and requests presented then are ignored.
- RAM is synchronous single-port: one access per request, write-first irrelevant (no concurrent read).
- PUSH followed immediately by POP at the same final ESP returns the pushed word.
- Reset values: state IDLE, `ready` 1 once reset deasserts (0 while asserted), `rsp_valid` 0, `rsp_err` 0, `pop_data` 0, `esp_out` 0, `esp_load` 0.
- Reset asserted during ACCESS suppresses the pending write. RAM contents are not cleared by reset.

## Structure
- Package `stack_pkg`: op codes (OP_PUSH, OP_POP, OP_PEEK), FSM state encoding (IDLE/ACCESS/RESP), default STACK_TOP.
- Sub-module `stack_ram`: DEPTH×32 single-port synchronous RAM (we, addr, wdata, rdata), no reset.
- The top level holds the FSM, latches, range/alignment checks and ESP arithmetic.

## Test plan
- Reset, then PUSH 32'hDEADBEEF with esp_in 0x400 → N+2: rsp_valid 1, err 0, esp_out 0x3FC, esp_load 1; ready 0 in N+1 and N+2.
- Then POP with esp_in 0x3FC → pop_data 32'hDEADBEEF, esp_out 0x400, esp_load 1; PEEK at 0x3FC before the POP → same data, esp_out 0x3FC, esp_load 0.
- POP with esp_in 0x400 (empty) and PUSH with esp_in 0x000 (full) → rsp_err 1, esp_load 0, esp_out = esp_in; a following PEEK shows the RAM is unchanged.
- esp_in 0x3FE or 0x404, and req_op 11 → rsp_err 1, no write.
- Fill 256 pushes from 0x400 down to 0x000, then pop all 256 → LIFO order is exact; the 257th push errors.
- Assert reset in ACCESS of a PUSH over known data → outputs return to reset values at once; after release, PEEK shows the old word at that address.
